stoch_stream_decoder: RTL and testbench

Receive-side converter for the stochastic datapath. It takes a serial stochastic bitstream (one SN bit per qualified cycle) and counts ones over a programmable power-of-two window. At the end of each window it publishes the count and its unipolar or bipolar binary value on a valid/ready output. It sits downstream of the LFSR/comparator SN generators and the XNOR/AND multipliers and replaces ad-hoc fixed-8-cycle counting: full-scale windows cannot overflow, and idle cycles in the stream are tolerated.

---
 rtl/stoch_pkg.sv | 26 ++
 rtl/stoch_win_counter.sv | 35 +++
 rtl/stoch_stream_decoder.sv | 135 +++++++++++++
 tb/tb_stoch_stream_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic datapath.
// Holds default window size, FSM state enum and bipolar conversion.
package stoch_pkg;

  localparam int WLM_DEF = 8;
  localparam int CNT_W_DEF = WLM_DEF + 1;
  localparam int VAL_W_DEF = WLM_DEF + 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // 2*ones - 2^w at full signed width; never overflows for ones <= 2^w
  function automatic logic signed [VAL_W_DEF-1:0] to_bipolar(
    input logic [CNT_W_DEF-1:0] ones,
    input logic [3:0]           w
  );
    logic [VAL_W_DEF-1:0] two_ones;
    logic [VAL_W_DEF-1:0] n;
    two_ones = {ones, 1'b0};
    n = VAL_W_DEF'(1) << w;
    return $signed(two_ones - n);
  endfunction

endpackage

// File: rtl/stoch_win_counter.sv
// Sample / ones counter pair for one stochastic window.
// Ports: clk, rst_n, clr, en, bit_in, w -> samp_cnt, ones_cnt, last.
module stoch_win_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  input  logic [3:0]    w,
  output logic [CW-1:0] samp_cnt,
  output logic [CW-1:0] ones_cnt,
  output logic          last
);

  logic [CW-1:0] n_m1;

  assign n_m1 = (CW'(1) << w) - CW'(1);
  assign last = (samp_cnt == n_m1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      samp_cnt <= '0;
      ones_cnt <= '0;
    end else if (clr) begin
      samp_cnt <= '0;
      ones_cnt <= '0;
    end else if (en) begin
      samp_cnt <= samp_cnt + CW'(1);
      ones_cnt <= ones_cnt + CW'(bit_in);
    end
  end

endmodule

// File: rtl/stoch_stream_decoder.sv
// Stochastic bitstream to binary decoder over a 2^w sample window.
// Ports: clk, rst_n (async, high), start/win_log2/bipolar/cont config,
//   sn_bit/sn_valid stream in, out_valid/out_ready result handshake,
//   out_ones, out_value, overrun (sticky), busy.
module stoch_stream_decoder
  import stoch_pkg::*;
#(
  parameter int WIN_LOG2_MAX = WLM_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [3:0]                   win_log2,
  input  logic                         bipolar,
  input  logic                         cont,
  input  logic                         sn_bit,
  input  logic                         sn_valid,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIN_LOG2_MAX:0]        out_ones,
  output logic signed [WIN_LOG2_MAX+1:0] out_value,
  output logic                         overrun,
  output logic                         busy
);

  localparam int CW = WIN_LOG2_MAX + 1;
  localparam int VW = WIN_LOG2_MAX + 2;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    w_clamp;
  logic [3:0]    w_q;
  logic          bipolar_q;
  logic          cont_q;
  logic          take;
  logic          done;
  logic          last;
  logic [CW-1:0] samp_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] ones_fin;
  logic [VW-1:0] value_nx;

  always_comb begin
    w_clamp = win_log2;
    if (win_log2 == 4'd0)
      w_clamp = 4'd1;
    else if (win_log2 > 4'(WIN_LOG2_MAX))
      w_clamp = 4'(WIN_LOG2_MAX);
  end

  assign take = (state == ACCUM) && sn_valid;
  assign done = take && last;

  stoch_win_counter #(
    .CW(CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start || done),
    .en       (take),
    .bit_in   (sn_bit),
    .w        (w_q),
    .samp_cnt (samp_cnt),
    .ones_cnt (ones_cnt),
    .last     (last)
  );

  // the final sample is folded in combinationally so the result
  // is registered on the completing edge itself
  assign ones_fin = ones_cnt + CW'(sn_bit);
  assign value_nx = bipolar_q ? VW'(to_bipolar(ones_fin, w_q))
                              : {1'b0, ones_fin};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = ACCUM;
      end
      ACCUM: begin
        if (start)
          state_nx = ACCUM;
        else if (done && !cont_q)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACCUM);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      w_q       <= 4'd1;
      bipolar_q <= 1'b0;
      cont_q    <= 1'b0;
    end else if (start) begin
      w_q       <= w_clamp;
      bipolar_q <= bipolar;
      cont_q    <= cont;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      out_ones  <= '0;
      out_value <= '0;
      overrun   <= 1'b0;
    end else begin
      if (start)
        overrun <= 1'b0;
      if (done) begin
        out_valid <= 1'b1;
        out_ones  <= ones_fin;
        out_value <= value_nx;
        if (out_valid && !out_ready)
          overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stoch_stream_decoder.sv
// Directed self-checking bench for stoch_stream_decoder.
// Drives inputs 1 time unit after each rising edge and checks there.
module tb_stoch_stream_decoder;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [3:0]        win_log2;
  logic              bipolar;
  logic              cont;
  logic              sn_bit;
  logic              sn_valid;
  logic              out_ready;
  logic              out_valid;
  logic [8:0]        out_ones;
  logic signed [9:0] out_value;
  logic              overrun;
  logic              busy;

  int total = 0;
  int bad = 0;

  stoch_stream_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_log2  (win_log2),
    .bipolar   (bipolar),
    .cont      (cont),
    .sn_bit    (sn_bit),
    .sn_valid  (sn_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_ones  (out_ones),
    .out_value (out_value),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    sn_valid = v;
    sn_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] w, input logic bp, input logic c);
    start = 1'b1;
    win_log2 = w;
    bipolar = bp;
    cont = c;
    sn_valid = 1'b0;
    sn_bit = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  logic pat3 [8] = '{1, 1, 0, 1, 1, 1, 0, 1};
  logic pat4 [8] = '{1, 0, 1, 0, 1, 0, 1, 1};

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    win_log2 = 4'd0;
    bipolar = 1'b0;
    cont = 1'b0;
    sn_bit = 1'b0;
    sn_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ones", int'(out_ones), 0);
    chk("rst_value", int'(out_value), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b0;
    step(1'b0, 1'b0);

    // unipolar w=4, 16 ones
    go(4'd4, 1'b0, 1'b0);
    chk("u4_busy", int'(busy), 1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    chk("u4_early", int'(out_valid), 0);
    step(1'b1, 1'b1);
    chk("u4_valid", int'(out_valid), 1);
    chk("u4_ones", int'(out_ones), 16);
    chk("u4_value", int'(out_value), 16);
    chk("u4_idle", int'(busy), 0);
    step(1'b0, 1'b0);
    chk("u4_pulse", int'(out_valid), 0);

    // bipolar w=3: 6 ones -> +4, then all zeros -> -8
    go(4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, pat3[i]);
    chk("b3_ones", int'(out_ones), 6);
    chk("b3_value", int'(out_value), 4);
    go(4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("b3z_ones", int'(out_ones), 0);
    chk("b3z_value", int'(out_value), -8);

    // gapped stream: invalid cycles carry 1s that must be ignored
    go(4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("gap_early", int'(out_valid), 0);
      step(1'b1, pat4[i]);
      if (i < 7) step(1'b0, 1'b1);
    end
    chk("gap_valid", int'(out_valid), 1);
    chk("gap_ones", int'(out_ones), 5);
    chk("gap_value", int'(out_value), 2);
    step(1'b0, 1'b0);

    // continuous w=2 with stalled consumer
    out_ready = 1'b0;
    go(4'd2, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("c_w1_valid", int'(out_valid), 1);
    chk("c_w1_ones", int'(out_ones), 3);
    chk("c_w1_ovr", int'(overrun), 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("c_hold", int'(out_ones), 3);
    step(1'b1, 1'b0);
    chk("c_w2_ones", int'(out_ones), 1);
    chk("c_w2_value", int'(out_value), 1);
    chk("c_w2_ovr", int'(overrun), 1);
    chk("c_w2_busy", int'(busy), 1);

    // start clears overrun; win_log2=0 gives a 2-sample window
    out_ready = 1'b1;
    go(4'd0, 1'b0, 1'b0);
    chk("s_ovr_clr", int'(overrun), 0);
    chk("s_xfer", int'(out_valid), 0);
    step(1'b1, 1'b1);
    chk("w0_early", int'(out_valid), 0);
    step(1'b1, 1'b0);
    chk("w0_valid", int'(out_valid), 1);
    chk("w0_ones", int'(out_ones), 1);
    chk("w0_busy", int'(busy), 0);

    // win_log2=15 clamps to 256 samples, all ones, no wrap
    go(4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) step(1'b1, 1'b1);
    chk("w256_early", int'(out_valid), 0);
    step(1'b1, 1'b1);
    chk("w256_valid", int'(out_valid), 1);
    chk("w256_ones", int'(out_ones), 256);
    chk("w256_value", int'(out_value), 256);

    // async reset with a pending result and a window in flight
    out_ready = 1'b0;
    go(4'd1, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("r_pre_valid", int'(out_valid), 1);
    chk("r_pre_ones", int'(out_ones), 2);
    step(1'b1, 1'b1);
    sn_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("r_valid", int'(out_valid), 0);
    chk("r_ones", int'(out_ones), 0);
    chk("r_value", int'(out_value), 0);
    chk("r_busy", int'(busy), 0);
    chk("r_ovr", int'(overrun), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    go(4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    chk("p_valid", int'(out_valid), 1);
    chk("p_ones", int'(out_ones), 4);
    chk("p_value", int'(out_value), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
